rs_latch_bank: RTL
==================

RS_LATCH_BANK -- requirements
Module: rs_latch_bank

Interface
REQ-001 The block SHALL have parameter N, default 8: number of independent set/reset channels (1..32).
REQ-002 The block SHALL have parameter EDGE_MODE, default 1: 1 = act on S rising edge / R falling edge; 0 = act on levels (S high, R low).
REQ-003 The block SHALL have parameter SET_DOMINANT, default 0: 1 = set wins a same-cycle set/reset on a channel; 0 = reset wins.
REQ-004 The block SHALL have parameter TW, default 8: width of the per-channel timeout counter.
REQ-005 The block SHALL have parameter TIMEOUT, default 0: cycles a set channel stays high before auto-clear; 0 disables auto-clear; legal range 0..2^TW-1.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port S, input, N bits: per-channel set request, active-high, synchronous to clk.
REQ-009 The block SHALL have port R, input, N bits: per-channel reset request, active-low, synchronous to clk.
REQ-010 The block SHALL have port clr, input, 1 bit: synchronous clear of all channels, active-high.
REQ-011 The block SHALL have port Q, output, N bits: registered latch state per channel.
REQ-012 The block SHALL have port chg, output, N bits: registered one-cycle pulse on each channel whose Q changed at that edge.
REQ-013 The block SHALL have port any, output, 1 bit: combinational OR of all Q bits.

Function
REQ-014 The block SHALL register S into s_prev and R into r_prev every cycle for edge detection.
REQ-015 With EDGE_MODE=1, the set event SHALL be S[i]=1 and s_prev[i]=0, and the reset event SHALL be R[i]=0 and r_prev[i]=1.
REQ-016 With EDGE_MODE=0, the set event SHALL be S[i]=1 and the reset event SHALL be R[i]=0.
REQ-017 A set event sampled at edge k SHALL drive Q[i]=1 after edge k (zero-cycle latency), and a reset event sampled at edge k SHALL drive Q[i]=0 after edge k.
REQ-018 When set and reset events coincide on a channel, SET_DOMINANT SHALL select the winner.
REQ-019 clr=1 SHALL force all Q to 0 at that edge, overriding set, reset and timeout.
REQ-020 When neither event occurs, Q[i] SHALL hold its value, except for timeout expiry.
REQ-021 With TIMEOUT>0, a winning set event SHALL load cnt[i]=TIMEOUT, including retrigger while Q[i] is already 1.
REQ-022 With TIMEOUT>0, while Q[i]=1 and no set event wins, cnt[i] SHALL decrement each cycle, and Q[i] SHALL clear at the edge where cnt[i]=1 decrements to 0, so Q[i] is high for exactly TIMEOUT cycles.
REQ-023 A winning set event in the expiry cycle SHALL reload the counter and keep Q[i]=1 with no chg pulse.
REQ-024 A reset event or clr SHALL zero cnt[i].
REQ-025 With TIMEOUT=0, the counters SHALL stay 0 and auto-clear SHALL never occur.
REQ-026 chg[i] SHALL equal next_Q[i] XOR Q[i], registered alongside Q; a set on an already-set channel SHALL produce no pulse.
REQ-027 Channels SHALL be fully independent; an event on channel i SHALL never affect channel j≠i.

Reset
REQ-028 reset=1 SHALL immediately (without a clock) force Q=0, chg=0, all cnt=0, s_prev=0 and r_prev=all-ones, so that idle-high R produces no spurious reset edge after release.
REQ-029 Reset asserted mid-timeout SHALL abandon the count, and after deassertion the channel SHALL stay 0 until a new set event.
REQ-030 The first edge after reset deassertion SHALL evaluate events normally, and S held high through reset SHALL count as a rising edge in EDGE_MODE=1.

Verification
REQ-031 The bench SHALL cover this case: N=8, EDGE_MODE=1, S[3] 0->1 held 5 cycles -> Q=8'h08 after that edge, with chg[3] pulsing 1 cycle only and no further set while S stays high.
REQ-032 The bench SHALL cover this case: R[3] 1->0 with Q[3]=1 -> Q[3]=0 after that edge and chg[3] pulses; R held low for 3 more cycles -> no further chg.
REQ-033 The bench SHALL cover this case: a same-cycle S[0] rise and R[0] fall, with SET_DOMINANT=0 -> Q[0]=0, and with SET_DOMINANT=1 -> Q[0]=1.
REQ-034 The bench SHALL cover this case: TIMEOUT=4, S[1] pulse at edge k -> Q[1]=1 for edges k..k+3 and 0 after edge k+4; a retrigger at k+2 -> Q[1] falls after k+6.
REQ-035 The bench SHALL cover this case: Q=8'hFF with clr=1 and S=8'hFF rising in the same cycle -> Q=8'h00 and chg=8'hFF.
REQ-036 The bench SHALL cover this case: reset pulsed asynchronously between edges with Q=8'h5A and active counters -> Q=0 and chg=0 immediately, with no activity after release until a new set.

Source files
------------

// File: rtl/rs_latch_bank.sv
// Bank of N independent set/reset latches with edge or level triggering,
// configurable same-cycle priority, a global clear and an optional auto-clear timeout.
module rs_latch_bank #(
  parameter int N            = 8,
  parameter int EDGE_MODE    = 1,
  parameter int SET_DOMINANT = 0,
  parameter int TW           = 8,
  parameter int TIMEOUT      = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] S,
  input  logic [N-1:0] R,
  input  logic         clr,
  output logic [N-1:0] Q,
  output logic [N-1:0] chg,
  output logic         any
);

  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);
  localparam logic [TW-1:0] CNT_ONE = TW'(1);

  logic [N-1:0]          q_r;
  logic [N-1:0]          chg_r;
  logic [N-1:0]          s_prev_r;
  logic [N-1:0]          r_prev_r;
  logic [N-1:0][TW-1:0]  cnt_r;

  logic [N-1:0]          set_ev_s;
  logic [N-1:0]          rst_ev_s;
  logic [N-1:0]          set_win_s;
  logic [N-1:0]          rst_win_s;
  logic [N-1:0]          q_nxt_s;
  logic [N-1:0][TW-1:0]  cnt_nxt_s;

  // Event detection and per-channel priority resolution
  always_comb begin
    if (EDGE_MODE != 0) begin
      set_ev_s = S & ~s_prev_r;
      rst_ev_s = ~R & r_prev_r;
    end else begin
      set_ev_s = S;
      rst_ev_s = ~R;
    end
    if (SET_DOMINANT != 0) begin
      set_win_s = set_ev_s;
      rst_win_s = rst_ev_s & ~set_ev_s;
    end else begin
      set_win_s = set_ev_s & ~rst_ev_s;
      rst_win_s = rst_ev_s;
    end
  end

  // Next latch state and timeout counter per channel
  always_comb begin
    q_nxt_s   = q_r;
    cnt_nxt_s = cnt_r;
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        q_nxt_s[i]   = 1'b0;
        cnt_nxt_s[i] = {TW{1'b0}};
      end else if (set_win_s[i]) begin
        q_nxt_s[i]   = 1'b1;
        cnt_nxt_s[i] = TO_VAL;
      end else if (rst_win_s[i]) begin
        q_nxt_s[i]   = 1'b0;
        cnt_nxt_s[i] = {TW{1'b0}};
      end else if ((TIMEOUT != 0) && q_r[i]) begin
        // Expiry on the 1->0 step keeps Q high for exactly TIMEOUT cycles
        if (cnt_r[i] == CNT_ONE) begin
          q_nxt_s[i]   = 1'b0;
          cnt_nxt_s[i] = {TW{1'b0}};
        end else begin
          q_nxt_s[i]   = q_r[i];
          cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
        end
      end else begin
        q_nxt_s[i]   = q_r[i];
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // State registers; r_prev resets high so an idle-high R gives no false reset edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r      <= {N{1'b0}};
      chg_r    <= {N{1'b0}};
      s_prev_r <= {N{1'b0}};
      r_prev_r <= {N{1'b1}};
      cnt_r    <= '0;
    end else begin
      q_r      <= q_nxt_s;
      chg_r    <= q_nxt_s ^ q_r;
      s_prev_r <= S;
      r_prev_r <= R;
      cnt_r    <= cnt_nxt_s;
    end
  end

  assign Q   = q_r;
  assign chg = chg_r;
  assign any = |q_r;

endmodule
